// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for multi_axis_state_controller and ctrl_mac.
//   state_t   : controller FSM states (IDLE, MAC, SAT)
//   term_t    : which feedback term the MAC is working on this cycle
//   acc_width : accumulator width that cannot overflow for the three terms
//   *_DEF     : default gains, shift and neutral angle
// ---------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      SAT  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      TERM_POS = 2'd0,
      TERM_VEL = 2'd1,
      TERM_REF = 2'd2
   } term_t;

   localparam int K_POS_DEF  = 326;
   localparam int K_VEL_DEF  = 326;
   localparam int K_REF_DEF  = 326;
   localparam int SHIFT_DEF  = 12;
   localparam int CENTER_DEF = 2048;

   // Three products of (POS_W+1)-bit operands and GAIN_W-bit gains summed:
   // two guard bits on top of the product width are sufficient.
   function automatic int acc_width(input int pos_w, input int gain_w);
      return pos_w + gain_w + 3;
   endfunction

endpackage

// File: rtl/ctrl_mac.sv
// ---------------------------------------------------------------------------
// ctrl_mac
// Shared signed multiply-accumulate unit with a registered result.
//   clock   in  system clock
//   reset   in  asynchronous active-high reset (clears the accumulator)
//   en      in  update the accumulator this cycle
//   clear   in  load the product instead of accumulating
//   sub     in  subtract the product from the accumulator (ignored on clear)
//   gain    in  signed gain, A_W bits
//   operand in  signed operand, B_W bits
//   acc     out registered signed accumulator, ACC_W bits
// ---------------------------------------------------------------------------
module ctrl_mac #(
   parameter int A_W   = 12,
   parameter int B_W   = 13,
   parameter int ACC_W = 27
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    clear,
   input  logic                    sub,
   input  logic signed [A_W-1:0]   gain,
   input  logic signed [B_W-1:0]   operand,
   output logic signed [ACC_W-1:0] acc
);

   localparam int P_W = A_W + B_W;

   logic signed [P_W-1:0]   prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_reg;
   logic signed [ACC_W-1:0] acc_next;

   always_comb begin
      prod     = gain * operand;
      prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
      if (clear) begin
         acc_next = prod_ext;
      end else if (sub) begin
         acc_next = acc_reg - prod_ext;
      end else begin
         acc_next = acc_reg + prod_ext;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_reg <= '0;
      end else if (en) begin
         acc_reg <= acc_next;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/multi_axis_state_controller.sv
// ---------------------------------------------------------------------------
// multi_axis_state_controller
// Full-state feedback u = K_POS*act + K_VEL*(act-prev_act) - K_REF*des for
// N_AXES axes, one shared MAC, three MAC cycles plus one SAT cycle per axis.
// All axis angles are published together with a one-cycle valid strobe.
//   clock        in  system clock
//   reset        in  asynchronous active-high reset
//   ctrl_tick    in  one-cycle sample strobe
//   desired_pos  in  packed, axis i at [i*POS_W +: POS_W]
//   actual_pos   in  packed, same layout
//   angle        out packed registered angles, axis i at [i*ANG_W +: ANG_W]
//   valid        out one-cycle pulse, angle updated this cycle
//   busy         out high while a computation is in progress
//   overrun      out one-cycle pulse when a tick is dropped
// ---------------------------------------------------------------------------
module multi_axis_state_controller
   import ctrl_pkg::*;
#(
   parameter int N_AXES  = 2,
   parameter int POS_W   = 12,
   parameter int ANG_W   = 12,
   parameter int GAIN_W  = 12,
   parameter int K_POS   = K_POS_DEF,
   parameter int K_VEL   = K_VEL_DEF,
   parameter int K_REF   = K_REF_DEF,
   parameter int SHIFT   = SHIFT_DEF,
   parameter int CENTER  = CENTER_DEF,
   parameter int ANG_MIN = 0,
   parameter int ANG_MAX = 4095
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      ctrl_tick,
   input  logic [N_AXES*POS_W-1:0]   desired_pos,
   input  logic [N_AXES*POS_W-1:0]   actual_pos,
   output logic [N_AXES*ANG_W-1:0]   angle,
   output logic                      valid,
   output logic                      busy,
   output logic                      overrun
);

   localparam int ACC_W = acc_width(POS_W, GAIN_W);
   localparam int OP_W  = POS_W + 1;
   localparam int R_W   = ACC_W + 2;
   localparam int AX_W  = (N_AXES > 1) ? $clog2(N_AXES) : 1;

   localparam logic [AX_W-1:0]          LAST_AXIS = AX_W'(N_AXES - 1);
   localparam logic signed [GAIN_W-1:0] G_POS     = GAIN_W'(K_POS);
   localparam logic signed [GAIN_W-1:0] G_VEL     = GAIN_W'(K_VEL);
   localparam logic signed [GAIN_W-1:0] G_REF     = GAIN_W'(K_REF);
   localparam logic signed [R_W-1:0]    CENTER_R  = R_W'(CENTER);
   localparam logic signed [R_W-1:0]    MIN_R     = R_W'(ANG_MIN);
   localparam logic signed [R_W-1:0]    MAX_R     = R_W'(ANG_MAX);
   localparam logic [ANG_W-1:0]         ANG_MIN_V = ANG_W'(ANG_MIN);
   localparam logic [ANG_W-1:0]         ANG_MAX_V = ANG_W'(ANG_MAX);
   // Reset angle is the neutral position, clamped like any computed result.
   localparam logic [ANG_W-1:0]         ANG_RST   = ANG_W'((CENTER < ANG_MIN) ? ANG_MIN :
                                                           (CENTER > ANG_MAX) ? ANG_MAX : CENTER);

   state_t                  state_reg, state_next;
   term_t                   term_reg, term_next;
   logic [AX_W-1:0]         axis_reg, axis_next;
   logic                    first_sample_reg;
   logic                    valid_reg, busy_reg, overrun_reg;

   logic [POS_W-1:0]        des_in       [N_AXES];
   logic [POS_W-1:0]        act_in       [N_AXES];
   logic [POS_W-1:0]        des_smp_reg  [N_AXES];
   logic [POS_W-1:0]        act_smp_reg  [N_AXES];
   logic [POS_W-1:0]        prev_act_reg [N_AXES];
   logic [ANG_W-1:0]        stage_reg    [N_AXES];
   logic [ANG_W-1:0]        angle_reg    [N_AXES];

   logic                    accept, drop, sat_now, publish;
   logic                    mac_en, mac_clear, mac_sub;
   logic signed [GAIN_W-1:0] mac_gain;
   logic signed [OP_W-1:0]  mac_op;
   logic signed [ACC_W-1:0] acc;
   logic [POS_W-1:0]        cur_act, cur_des, cur_prev;
   logic signed [OP_W-1:0]  vel;
   logic signed [ACC_W-1:0] acc_sh;
   logic signed [R_W-1:0]   r_wide;
   logic [ANG_W-1:0]        r_clamped;

   genvar gi;
   generate
      for (gi = 0; gi < N_AXES; gi++) begin : g_axis_io
         assign des_in[gi]                 = desired_pos[gi*POS_W +: POS_W];
         assign act_in[gi]                 = actual_pos[gi*POS_W +: POS_W];
         assign angle[gi*ANG_W +: ANG_W]   = angle_reg[gi];
      end
   endgenerate

   // ---------------- FSM next state ----------------
   always_comb begin
      state_next = state_reg;
      term_next  = term_reg;
      axis_next  = axis_reg;
      accept     = 1'b0;
      drop       = 1'b0;
      sat_now    = 1'b0;
      publish    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (ctrl_tick) begin
               accept     = 1'b1;
               axis_next  = '0;
               term_next  = TERM_POS;
               state_next = MAC;
            end
         end
         MAC: begin
            drop = ctrl_tick;
            case (term_reg)
               TERM_POS: term_next = TERM_VEL;
               TERM_VEL: term_next = TERM_REF;
               default: begin
                  term_next  = TERM_POS;
                  state_next = SAT;
               end
            endcase
         end
         SAT: begin
            drop    = ctrl_tick;
            sat_now = 1'b1;
            if (axis_reg == LAST_AXIS) begin
               publish    = 1'b1;
               state_next = IDLE;
            end else begin
               axis_next  = axis_reg + AX_W'(1);
               state_next = MAC;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- MAC operand selection ----------------
   always_comb begin
      cur_act   = act_smp_reg[axis_reg];
      cur_des   = des_smp_reg[axis_reg];
      cur_prev  = prev_act_reg[axis_reg];
      vel       = $signed({1'b0, cur_act}) - $signed({1'b0, cur_prev});
      mac_en    = (state_reg == MAC);
      mac_clear = 1'b0;
      mac_sub   = 1'b0;
      mac_gain  = G_POS;
      mac_op    = $signed({1'b0, cur_act});
      case (term_reg)
         TERM_POS: mac_clear = 1'b1;
         TERM_VEL: begin
            mac_gain = G_VEL;
            // No history yet after reset: a velocity estimate would be garbage.
            mac_op   = first_sample_reg ? '0 : vel;
         end
         default: begin
            mac_gain = G_REF;
            mac_op   = $signed({1'b0, cur_des});
            mac_sub  = 1'b1;
         end
      endcase
   end

   ctrl_mac #(
      .A_W   (GAIN_W),
      .B_W   (OP_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clock   (clock),
      .reset   (reset),
      .en      (mac_en),
      .clear   (mac_clear),
      .sub     (mac_sub),
      .gain    (mac_gain),
      .operand (mac_op),
      .acc     (acc)
   );

   // ---------------- Shift, re-centre, clamp ----------------
   // Arithmetic shift floors toward minus infinity; two extra bits keep the
   // CENTER addition from wrapping before the clamp compares.
   always_comb begin
      acc_sh    = acc >>> SHIFT;
      r_wide    = {{2{acc_sh[ACC_W-1]}}, acc_sh} + CENTER_R;
      if (r_wide < MIN_R) begin
         r_clamped = ANG_MIN_V;
      end else if (r_wide > MAX_R) begin
         r_clamped = ANG_MAX_V;
      end else begin
         r_clamped = r_wide[ANG_W-1:0];
      end
   end

   // ---------------- State and register arrays ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         term_reg         <= TERM_POS;
         axis_reg         <= '0;
         first_sample_reg <= 1'b1;
         valid_reg        <= 1'b0;
         busy_reg         <= 1'b0;
         overrun_reg      <= 1'b0;
         for (int i = 0; i < N_AXES; i++) begin
            des_smp_reg[i]  <= '0;
            act_smp_reg[i]  <= '0;
            prev_act_reg[i] <= '0;
            stage_reg[i]    <= ANG_RST;
            angle_reg[i]    <= ANG_RST;
         end
      end else begin
         state_reg   <= state_next;
         term_reg    <= term_next;
         axis_reg    <= axis_next;
         valid_reg   <= publish;
         // Busy rises the cycle after the tick edge and falls with valid.
         busy_reg    <= (state_reg != IDLE) && !publish;
         overrun_reg <= drop;
         if (publish) begin
            first_sample_reg <= 1'b0;
         end
         for (int i = 0; i < N_AXES; i++) begin
            if (accept) begin
               des_smp_reg[i] <= des_in[i];
               act_smp_reg[i] <= act_in[i];
            end
            if (sat_now && (axis_reg == AX_W'(i))) begin
               stage_reg[i]    <= r_clamped;
               prev_act_reg[i] <= act_smp_reg[i];
            end
            // The last axis's result is written to staging on this same
            // edge, so it is forwarded directly.
            if (publish) begin
               angle_reg[i] <= (axis_reg == AX_W'(i)) ? r_clamped : stage_reg[i];
            end
         end
      end
   end

   assign valid   = valid_reg;
   assign busy    = busy_reg;
   assign overrun = overrun_reg;

endmodule
